// File: rtl/uart_echo_responder_pkg.sv
// rtl/uart_echo_responder_pkg.sv - shared byte width and transmit FSM encoding
package uart_echo_responder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_echo_responder_sync_fifo.sv
// rtl/uart_echo_responder_sync_fifo.sv - show-ahead byte FIFO with extra-MSB pointers
module uart_echo_responder_sync_fifo
    import uart_echo_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              pop,
    output logic [BYTE_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [BYTE_W-1:0] mem [DEPTH];

    // Full/empty come from the pre-edge pointers, so a same-cycle pop never frees room for a push
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - buffers uart_rx bytes and replays them through uart_tx
module uart_echo_responder
    import uart_echo_responder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter bit ECHO_ENABLE  = 1'b1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic [BYTE_W-1:0] last_byte,
    output logic              overflow,
    output logic [15:0]       rx_count
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    tx_state_t         state;
    logic [CW-1:0]     busy_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_head;
    logic              pop_req;

    assign pop_req = ECHO_ENABLE && (state == IDLE) && !fifo_empty && tx_ready;

    uart_echo_responder_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (pop_req),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            last_byte <= '0;
            overflow  <= 1'b0;
            rx_count  <= '0;
        end else begin
            tx_start <= 1'b0;
            if (rx_valid) begin
                last_byte <= rx_data;
                if (fifo_full) begin
                    overflow <= 1'b1;
                end else begin
                    rx_count <= rx_count + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (pop_req) begin
                        tx_data  <= fifo_head;
                        tx_start <= 1'b1;
                        busy_cnt <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // A transmitter that never drops ready is treated as having sent the byte
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        state <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
